// File: rtl/nco_ctrl_fsm.sv
// NCO bank control: streamed LUT load, fixed-frequency run and linear frequency sweep.
// Outputs are registered (1 cycle after the deciding edge); the load stream is held off by ld_ready_o outside S_LOAD.
module nco_ctrl_fsm #(
  parameter int NUM_CH  = 2,
  parameter int FSTEP_W = 14,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 256,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en_i,
  input  logic               load_req_i,
  input  logic [CH_W-1:0]    ch_sel_i,
  input  logic               ld_valid_i,
  input  logic [DATA_W-1:0]  ld_data_i,
  output logic               ld_ready_o,
  input  logic               run_i,
  input  logic               sweep_en_i,
  input  logic [NUM_CH-1:0]  ch_en_i,
  input  logic [FSTEP_W-1:0] fstep_i,
  input  logic [FSTEP_W-1:0] fstep_start_i,
  input  logic [FSTEP_W-1:0] fstep_stop_i,
  input  logic [FSTEP_W-1:0] sweep_inc_i,
  input  logic [15:0]        dwell_i,
  output logic [NUM_CH-1:0]  nco_we_o,
  output logic [ADDR_W-1:0]  nco_addr_o,
  output logic [DATA_W-1:0]  nco_data_o,
  output logic [FSTEP_W-1:0] nco_freq_step_o,
  output logic [NUM_CH-1:0]  nco_run_o,
  output logic               busy_o,
  output logic               load_done_o,
  output logic               sweep_wrap_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_SWEEP = 2'd3
  } state_t;

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]        dwell_q, dwell_d;
  logic [NUM_CH-1:0]  we_d, run_d, ch_onehot;
  logic [ADDR_W-1:0]  waddr_d;
  logic [DATA_W-1:0]  wdata_d;
  logic [FSTEP_W-1:0] freq_d;
  logic               done_d, wrap_d;
  logic               ch_ok, ld_hs, last_word;
  logic [FSTEP_W:0]   step_sum;

  assign ld_ready_o = (state_q == S_LOAD);
  assign busy_o     = (state_q != S_IDLE);
  assign ch_ok      = ({1'b0, ch_sel_i} < NUM_CH_L);
  assign ld_hs      = ld_valid_i & ld_ready_o;
  // DEPTH is a power of two, so the final word sits at the all-ones address.
  assign last_word  = &addr_q;
  // One extra bit so an overflowing step is still seen as passing the stop bound.
  assign step_sum   = {1'b0, nco_freq_step_o} + {1'b0, sweep_inc_i};

  always_comb begin
    ch_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_onehot[i] = (ch_q == CH_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    dwell_d = dwell_q;
    we_d    = '0;
    waddr_d = nco_addr_o;
    wdata_d = nco_data_o;
    freq_d  = nco_freq_step_o;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    if (!en_i) begin
      state_d = S_IDLE;
      addr_d  = '0;
      dwell_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_req_i && ch_ok) begin
            state_d = S_LOAD;
            ch_d    = ch_sel_i;
            addr_d  = '0;
          end else if (run_i) begin
            if (sweep_en_i) begin
              state_d = S_SWEEP;
              freq_d  = fstep_start_i;
              dwell_d = '0;
            end else begin
              state_d = S_RUN;
              freq_d  = fstep_i;
            end
          end
        end

        S_LOAD: begin
          if (ld_hs) begin
            we_d    = ch_onehot;
            waddr_d = addr_q;
            wdata_d = ld_data_i;
            addr_d  = addr_q + 1'b1;
            if (last_word) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end

        S_RUN: begin
          freq_d = fstep_i;
          if (load_req_i && ch_ok) begin
            state_d = S_LOAD;
            ch_d    = ch_sel_i;
            addr_d  = '0;
          end else if (!run_i) begin
            state_d = S_IDLE;
          end
        end

        S_SWEEP: begin
          if (dwell_q == dwell_i) begin
            dwell_d = '0;
            if (step_sum > {1'b0, fstep_stop_i}) begin
              freq_d = fstep_start_i;
              wrap_d = 1'b1;
            end else begin
              freq_d = step_sum[FSTEP_W-1:0];
            end
          end else begin
            dwell_d = dwell_q + 16'd1;
          end

          if (load_req_i && ch_ok) begin
            state_d = S_LOAD;
            ch_d    = ch_sel_i;
            addr_d  = '0;
            dwell_d = '0;
          end else if (!run_i) begin
            state_d = S_IDLE;
            dwell_d = '0;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    run_d = ((state_d == S_RUN) || (state_d == S_SWEEP)) ? ch_en_i : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      ch_q            <= '0;
      addr_q          <= '0;
      dwell_q         <= '0;
      nco_we_o        <= '0;
      nco_addr_o      <= '0;
      nco_data_o      <= '0;
      nco_freq_step_o <= '0;
      nco_run_o       <= '0;
      load_done_o     <= 1'b0;
      sweep_wrap_o    <= 1'b0;
    end else begin
      state_q         <= state_d;
      ch_q            <= ch_d;
      addr_q          <= addr_d;
      dwell_q         <= dwell_d;
      nco_we_o        <= we_d;
      nco_addr_o      <= waddr_d;
      nco_data_o      <= wdata_d;
      nco_freq_step_o <= freq_d;
      nco_run_o       <= run_d;
      load_done_o     <= done_d;
      sweep_wrap_o    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_nco_ctrl_fsm.sv
// Directed sequence with randomized data, gaps and sweep settings for nco_ctrl_fsm;
// expected sweep outputs come from a precomputed list of visited frequencies.
module tb_nco_ctrl_fsm;

  localparam int NUM_CH  = 2;
  localparam int FSTEP_W = 14;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 8;

  logic               clk;
  logic               reset_n;
  logic               en_i;
  logic               load_req_i;
  logic [0:0]         ch_sel_i;
  logic               ld_valid_i;
  logic [DATA_W-1:0]  ld_data_i;
  logic               ld_ready_o;
  logic               run_i;
  logic               sweep_en_i;
  logic [NUM_CH-1:0]  ch_en_i;
  logic [FSTEP_W-1:0] fstep_i;
  logic [FSTEP_W-1:0] fstep_start_i;
  logic [FSTEP_W-1:0] fstep_stop_i;
  logic [FSTEP_W-1:0] sweep_inc_i;
  logic [15:0]        dwell_i;
  logic [NUM_CH-1:0]  nco_we_o;
  logic [ADDR_W-1:0]  nco_addr_o;
  logic [DATA_W-1:0]  nco_data_o;
  logic [FSTEP_W-1:0] nco_freq_step_o;
  logic [NUM_CH-1:0]  nco_run_o;
  logic               busy_o;
  logic               load_done_o;
  logic               sweep_wrap_o;

  int vectors     = 0;
  int miscompares = 0;

  nco_ctrl_fsm #(
    .NUM_CH (NUM_CH),
    .FSTEP_W(FSTEP_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .en_i           (en_i),
    .load_req_i     (load_req_i),
    .ch_sel_i       (ch_sel_i),
    .ld_valid_i     (ld_valid_i),
    .ld_data_i      (ld_data_i),
    .ld_ready_o     (ld_ready_o),
    .run_i          (run_i),
    .sweep_en_i     (sweep_en_i),
    .ch_en_i        (ch_en_i),
    .fstep_i        (fstep_i),
    .fstep_start_i  (fstep_start_i),
    .fstep_stop_i   (fstep_stop_i),
    .sweep_inc_i    (sweep_inc_i),
    .dwell_i        (dwell_i),
    .nco_we_o       (nco_we_o),
    .nco_addr_o     (nco_addr_o),
    .nco_data_o     (nco_data_o),
    .nco_freq_step_o(nco_freq_step_o),
    .nco_run_o      (nco_run_o),
    .busy_o         (busy_o),
    .load_done_o    (load_done_o),
    .sweep_wrap_o   (sweep_wrap_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  32'(busy_o), 32'd0);
    check({tag, "_ready"}, 32'(ld_ready_o), 32'd0);
    check({tag, "_we"},    32'(nco_we_o), 32'd0);
    check({tag, "_addr"},  32'(nco_addr_o), 32'd0);
    check({tag, "_data"},  32'(nco_data_o), 32'd0);
    check({tag, "_freq"},  32'(nco_freq_step_o), 32'd0);
    check({tag, "_run"},   32'(nco_run_o), 32'd0);
    check({tag, "_done"},  32'(load_done_o), 32'd0);
    check({tag, "_wrap"},  32'(sweep_wrap_o), 32'd0);
  endtask

  // Streams n words (data = idx*mult+base) into an already-started load with random valid gaps.
  task automatic load_words(input int ch, input int n, input int mult, input int base);
    int idx;
    int budget;
    bit hs;
    logic [DATA_W-1:0] dat;
    logic [NUM_CH-1:0] exp_we;
    idx    = 0;
    budget = 0;
    exp_we = NUM_CH'(1 << ch);
    while (idx < n && budget < 4000) begin
      ld_valid_i = ($urandom_range(0, 2) != 0);
      dat        = DATA_W'((idx * mult + base) & 255);
      ld_data_i  = dat;
      hs         = ld_valid_i;
      tick();
      budget++;
      if (hs) begin
        check("ld_we",   32'(nco_we_o), 32'(exp_we));
        check("ld_addr", 32'(nco_addr_o), 32'(idx));
        check("ld_data", 32'(nco_data_o), 32'(dat));
        check("ld_done", 32'(load_done_o), 32'(idx == DEPTH - 1));
        idx++;
      end else begin
        check("ld_gap_we",   32'(nco_we_o), 32'd0);
        check("ld_gap_done", 32'(load_done_o), 32'd0);
      end
      check("ld_ready", 32'(ld_ready_o), 32'(idx < DEPTH));
    end
    ld_valid_i = 1'b0;
    check("ld_budget", 32'(idx), 32'(n));
  endtask

  // Enters a sweep and compares against the list of frequencies the sweep visits.
  // mode 0: leave via run_i low; 1: leave via en_i low; 2: reset mid-sweep.
  task automatic sweep_run(input int start, input int inc, input int stop, input int dwell,
                           input logic [NUM_CH-1:0] chen, input int ncyc, input int mode);
    int vals[$];
    bit wraps;
    int v;
    int step;
    int exp_v;
    int last;
    bit exp_w;
    fstep_start_i = FSTEP_W'(start);
    sweep_inc_i   = FSTEP_W'(inc);
    fstep_stop_i  = FSTEP_W'(stop);
    dwell_i       = 16'(dwell);
    ch_en_i       = chen;
    if (start > stop) begin
      vals.push_back(start);
      wraps = 1'b1;
    end else if (inc == 0) begin
      vals.push_back(start);
      wraps = 1'b0;
    end else begin
      v = start;
      while (v <= stop) begin
        vals.push_back(v);
        v += inc;
      end
      wraps = 1'b1;
    end
    last       = start;
    sweep_en_i = 1'b1;
    run_i      = 1'b1;
    tick();
    sweep_en_i = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) tick();
      step  = k / (dwell + 1);
      exp_v = vals[step % vals.size()];
      exp_w = wraps && (k > 0) && (k % (dwell + 1) == 0) && (step % vals.size() == 0);
      check("sw_freq", 32'(nco_freq_step_o), 32'(exp_v));
      check("sw_wrap", 32'(sweep_wrap_o), 32'(exp_w));
      check("sw_run",  32'(nco_run_o), 32'(chen));
      check("sw_busy", 32'(busy_o), 32'd1);
      last = exp_v;
    end
    case (mode)
      0: begin
        run_i = 1'b0;
        tick();
        check("sw_exit_busy", 32'(busy_o), 32'd0);
        check("sw_exit_run",  32'(nco_run_o), 32'd0);
      end
      1: begin
        en_i = 1'b0;
        tick();
        check("sw_en_busy", 32'(busy_o), 32'd0);
        check("sw_en_run",  32'(nco_run_o), 32'd0);
        check("sw_en_hold", 32'(nco_freq_step_o), 32'(last));
        en_i  = 1'b1;
        run_i = 1'b0;
        tick();
        check("sw_en_idle", 32'(busy_o), 32'd0);
      end
      default: begin
        reset_n = 1'b0;
        run_i   = 1'b0;
        tick();
        tick();
        check_zero("sw_rst");
        reset_n = 1'b1;
        tick();
        check("sw_rst_idle", 32'(busy_o), 32'd0);
      end
    endcase
  endtask

  initial begin
    reset_n       = 1'b0;
    en_i          = 1'b0;
    load_req_i    = 1'b0;
    ch_sel_i      = '0;
    ld_valid_i    = 1'b0;
    ld_data_i     = '0;
    run_i         = 1'b0;
    sweep_en_i    = 1'b0;
    ch_en_i       = '0;
    fstep_i       = '0;
    fstep_start_i = '0;
    fstep_stop_i  = '0;
    sweep_inc_i   = '0;
    dwell_i       = '0;
    tick();
    tick();
    check_zero("reset");

    reset_n = 1'b1;
    en_i    = 1'b1;
    tick();
    check("idle_busy", 32'(busy_o), 32'd0);

    // Full load of channel 1, data equals address.
    load_req_i = 1'b1;
    ch_sel_i   = 1'b1;
    tick();
    load_req_i = 1'b0;
    check("load_start_ready", 32'(ld_ready_o), 32'd1);
    check("load_start_busy",  32'(busy_o), 32'd1);
    load_words(1, DEPTH, 1, 0);
    tick();
    check("load_after_we",   32'(nco_we_o), 32'd0);
    check("load_after_done", 32'(load_done_o), 32'd0);
    check("load_after_addr", 32'(nco_addr_o), 32'd255);

    // Abort after 100 words, then a fresh load must restart at address 0.
    load_req_i = 1'b1;
    ch_sel_i   = 1'b0;
    tick();
    load_req_i = 1'b0;
    load_words(0, 100, 3, 5);
    en_i = 1'b0;
    tick();
    check("abort_busy",  32'(busy_o), 32'd0);
    check("abort_ready", 32'(ld_ready_o), 32'd0);
    check("abort_done",  32'(load_done_o), 32'd0);
    check("abort_we",    32'(nco_we_o), 32'd0);
    en_i = 1'b1;
    tick();
    load_req_i = 1'b1;
    ch_sel_i   = 1'b0;
    tick();
    load_req_i = 1'b0;
    check("reload_ready", 32'(ld_ready_o), 32'd1);
    load_words(0, DEPTH, 5, 17);

    // Load beats run when both are requested from IDLE.
    load_req_i = 1'b1;
    run_i      = 1'b1;
    ch_sel_i   = 1'b1;
    ch_en_i    = 2'b11;
    tick();
    load_req_i = 1'b0;
    run_i      = 1'b0;
    check("prio_ready", 32'(ld_ready_o), 32'd1);
    check("prio_run",   32'(nco_run_o), 32'd0);
    en_i = 1'b0;
    tick();
    en_i = 1'b1;
    check("prio_idle", 32'(busy_o), 32'd0);

    // Fixed run on channel 0 with a ramping, then random, tuning word.
    ch_en_i    = 2'b01;
    sweep_en_i = 1'b0;
    fstep_i    = FSTEP_W'(5);
    run_i      = 1'b1;
    tick();
    check("run_busy",  32'(busy_o), 32'd1);
    check("run_first", 32'(nco_run_o), 32'b01);
    for (int f = 5; f <= 9; f++) begin
      fstep_i = FSTEP_W'(f);
      tick();
      check("run_freq", 32'(nco_freq_step_o), 32'(f));
      check("run_mask", 32'(nco_run_o), 32'b01);
    end
    for (int r = 0; r < 12; r++) begin
      logic [FSTEP_W-1:0] f_r;
      logic [NUM_CH-1:0]  m_r;
      f_r     = FSTEP_W'($urandom_range(0, 16383));
      m_r     = NUM_CH'($urandom_range(0, 3));
      fstep_i = f_r;
      ch_en_i = m_r;
      tick();
      check("run_rand_freq", 32'(nco_freq_step_o), 32'(f_r));
      check("run_rand_mask", 32'(nco_run_o), 32'(m_r));
    end

    // A load request while running stops the channels.
    ch_en_i    = 2'b01;
    load_req_i = 1'b1;
    ch_sel_i   = 1'b0;
    tick();
    load_req_i = 1'b0;
    check("runload_run",   32'(nco_run_o), 32'd0);
    check("runload_ready", 32'(ld_ready_o), 32'd1);
    run_i = 1'b0;
    en_i  = 1'b0;
    tick();
    en_i = 1'b1;
    check("runload_idle", 32'(busy_o), 32'd0);

    sweep_run(100, 30, 200, 2, 2'b11, 30, 0);
    for (int r = 0; r < 4; r++) begin
      int s_st;
      int s_inc;
      int s_sp;
      int s_dw;
      s_st  = int'($urandom_range(0, 300));
      s_inc = int'($urandom_range(0, 60));
      s_sp  = int'($urandom_range(0, 400));
      s_dw  = int'($urandom_range(0, 4));
      sweep_run(s_st, s_inc, s_sp, s_dw, NUM_CH'($urandom_range(1, 3)), 40, 0);
    end
    sweep_run(300, 10, 200, 1, 2'b10, 12, 0);
    sweep_run(50, 0, 60, 0, 2'b01, 10, 0);
    sweep_run(16380, 16383, 16383, 0, 2'b11, 8, 1);
    sweep_run(100, 30, 200, 2, 2'b11, 7, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
